// File: rtl/id_ex_hazard_ctrl.sv
// Stall/bubble/flush controller beside the IF/ID and ID/EX registers: load-use stall,
// taken-branch flush and mem_busy freeze. Optional counters: define HAZARD_PERF_CNT_EN.
module id_ex_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lu_stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StFlush   = 2'd2
  } state_e;

  localparam logic [3:0] CntReload = 4'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;
  logic       lu_entry;

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    id_ex_hold   = 1'b0;
    lu_entry     = 1'b0;

    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = StRun;
      cnt_d        = 4'd0;
    end else if (mem_busy) begin
      // Freeze: hold everything; EX re-presents branch/load after the freeze.
      id_ex_hold = 1'b1;
    end else begin
      case (state_q)
        StRun, StLuStall: begin
          if (branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES == 1) begin
              state_d = StRun;
            end else begin
              state_d = StFlush;
              cnt_d   = CntReload;
            end
          end else if ((state_q == StRun) && lu) begin
            id_ex_bubble = 1'b1;
            state_d      = StLuStall;
            lu_entry     = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_d     = StRun;
          end
        end
        StFlush: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (branch_taken) begin
            cnt_d = CntReload;
          end else if (cnt_q == 4'd1) begin
            state_d = StRun;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q, freeze_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q     <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      // All counters saturate at all-ones.
      if (lu_entry && (lu_cnt_q != '1))        lu_cnt_q     <= lu_cnt_q + CNT_W'(1);
      if (if_id_flush && (flush_cnt_q != '1))  flush_cnt_q  <= flush_cnt_q + CNT_W'(1);
      if (mem_busy && (freeze_cnt_q != '1))    freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  assign lu_stall_count = lu_cnt_q;
  assign flush_count    = flush_cnt_q;
  assign freeze_count   = freeze_cnt_q;
`else
  logic unused_lu_entry;
  assign unused_lu_entry = lu_entry;
  assign lu_stall_count  = '0;
  assign flush_count     = '0;
  assign freeze_count    = '0;
`endif

endmodule
